cache_mem_arbiter: RTL

- Shares the single RAM port between the instruction cache and the data cache.
- Sequences one word access at a time. The dcache has priority, and a bounded-streak rule prevents icache starvation.
- Sits between the icache/dcache miss and writeback paths and the RAM model, inside memory control.
- Each access is registered-grant: once an owner is granted, the grant does not switch until that access completes or is aborted.

---
 rtl/cache_mem_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the single RAM word port between icache and dcache.
// dcache has priority; a saturating dcache streak counter forces an icache grant.
module cache_mem_arbiter #(
    parameter int MAX_DSTREAK = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ram_ready
);

    localparam int DSW = $clog2(MAX_DSTREAK + 1);
    localparam logic [DSW-1:0] DS_MAX = DSW'(MAX_DSTREAK);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } state_t;

    state_t         state_r;
    state_t         next_state_s;
    logic [DSW-1:0] dstreak_r;
    logic [DSW-1:0] dstreak_nxt_s;
    logic           i_done_s;
    logic           d_done_s;

    // State register; reset drops any in-flight access.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // dcache streak register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dstreak_r <= '0;
        end else begin
            dstreak_r <= dstreak_nxt_s;
        end
    end

    // Next-state arbitration and RAM/requester outputs.
    always_comb begin
        next_state_s = state_r;
        iwait        = 1'b1;
        dwait        = 1'b1;
        iload        = 32'h0000_0000;
        dload        = 32'h0000_0000;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = 32'h0000_0000;
        ramstore     = 32'h0000_0000;
        i_done_s     = 1'b0;
        d_done_s     = 1'b0;
        case (state_r)
            IDLE: begin
                // Streak uses the registered count so the decision is glitch-free.
                if ((dREN || dWEN) && !(iREN && (dstreak_r == DS_MAX))) begin
                    next_state_s = DGRANT;
                end else if (iREN) begin
                    next_state_s = IGRANT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            IGRANT: begin
                if (!iREN) begin
                    next_state_s = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (ram_ready) begin
                        iwait        = 1'b0;
                        iload        = ramload;
                        i_done_s     = 1'b1;
                        next_state_s = IDLE;
                    end else begin
                        next_state_s = IGRANT;
                    end
                end
            end
            DGRANT: begin
                if (!(dREN || dWEN)) begin
                    next_state_s = IDLE;
                end else begin
                    ramaddr = daddr;
                    if (dWEN) begin
                        ramWEN   = 1'b1;
                        ramstore = dstore;
                    end else begin
                        ramREN   = 1'b1;
                    end
                    if (ram_ready) begin
                        dwait        = 1'b0;
                        dload        = dWEN ? 32'h0000_0000 : ramload;
                        d_done_s     = 1'b1;
                        next_state_s = IDLE;
                    end else begin
                        next_state_s = DGRANT;
                    end
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Streak counts dcache wins only while the icache is actually waiting.
    always_comb begin
        dstreak_nxt_s = dstreak_r;
        if (!iREN || i_done_s) begin
            dstreak_nxt_s = '0;
        end else if (d_done_s && (dstreak_r != DS_MAX)) begin
            dstreak_nxt_s = dstreak_r + DSW'(1);
        end else begin
            dstreak_nxt_s = dstreak_r;
        end
    end

endmodule
